// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 CUT: flushes the CUT, drives LFSR patterns and compacts G17 into a SISR.
// Optional build macro S27_BIST_SIG_OUT_EN exposes the live signature on port SIG.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for START, stimulus held at zero
// S_FLUSH | FLUSH_PAT applied for FLUSH_CYCLES cycles, no compaction
// S_RUN   | LFSR pattern applied, G17 compacted every edge
// S_DONE  | run complete, DONE/PASS held until the next START
module s27_bist_ctrl #(
    parameter int unsigned PAT_COUNT    = 64,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [3:0]  FLUSH_PAT    = 4'b0000,
    parameter logic [3:0]  LFSR_SEED    = 4'b1001,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic       CK,
    input  logic       RSTN,
    input  logic       START,
    output logic       G0,
    output logic       G1,
    output logic       G2,
    output logic       G3,
    input  logic       G17,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS
`ifdef S27_BIST_SIG_OUT_EN
    ,
    output logic [7:0] SIG
`endif
);

    localparam logic [3:0] SEED       = (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] PAT_LAST   = 8'(PAT_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  pat_cnt_q, pat_cnt_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic [7:0]  sig_q, sig_d;
    logic [3:0]  g_q, g_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        start_en_q, start_en_d;
    logic        start_ok;

    // START is not honoured on the first edge after reset release.
    assign start_ok = START && start_en_q;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= 4'd0;
            pat_cnt_q   <= 8'd0;
            lfsr_q      <= SEED;
            sig_q       <= 8'h00;
            g_q         <= 4'b0000;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            start_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            lfsr_q      <= lfsr_d;
            sig_q       <= sig_d;
            g_q         <= g_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            start_en_q  <= start_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        lfsr_d      = lfsr_q;
        sig_d       = sig_q;
        done_d      = done_q;
        pass_d      = pass_q;
        start_en_d  = 1'b1;
        g_d         = 4'b0000;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 4'd0;
                    pat_cnt_d   = 8'd0;
                    sig_d       = 8'h00;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    lfsr_d      = SEED;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                // G17 reflects the pattern currently on G0..G3, i.e. lfsr_q.
                sig_d  = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ G17};
                lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
                if (pat_cnt_q != 8'hFF) begin
                    pat_cnt_d = pat_cnt_q + 8'd1;
                end
                if (pat_cnt_q == PAT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (sig_d == GOLDEN_SIG);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stimulus is registered, so it follows the state being entered.
        case (state_d)
            S_FLUSH: g_d = FLUSH_PAT;
            S_RUN:   g_d = lfsr_d;
            default: g_d = 4'b0000;
        endcase
    end

    assign G0   = g_q[0];
    assign G1   = g_q[1];
    assign G2   = g_q[2];
    assign G3   = g_q[3];
    assign BUSY = (state_q == S_FLUSH) || (state_q == S_RUN);
    assign DONE = done_q;
    assign PASS = pass_q;

`ifdef S27_BIST_SIG_OUT_EN
    assign SIG = sig_q;
`endif

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Self-checking bench for s27_bist_ctrl: vector table, hand sequences and randomized runs vs a reference model.
module tb_s27_bist_ctrl;

    localparam int F = 3;
    localparam int P = 64;
    localparam logic [3:0] SEED = 4'b1001;

    logic CK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CK = ~CK;

    int errs = 0;
    int checks = 0;

    // PAT_COUNT=4 instance
    logic start_4 = 1'b0, g17_4 = 1'b0;
    wire [3:0] g_4;
    wire busy_4, done_4, pass_4;
    logic [7:0] sig_4;
    // default instance
    logic start_64 = 1'b0, g17_64 = 1'b0;
    wire [3:0] g_64;
    wire busy_64, done_64, pass_64;
    logic [7:0] sig_64;
    // PAT_COUNT=1 instances, G17 tied high
    logic start_1 = 1'b0;
    wire [3:0] g_1a, g_1b;
    wire busy_1a, done_1a, pass_1a, busy_1b, done_1b, pass_1b;
    logic [7:0] sig_1a, sig_1b;

    s27_bist_ctrl #(.PAT_COUNT(4)) u4 (
        .CK(CK), .RSTN(RSTN), .START(start_4),
        .G0(g_4[0]), .G1(g_4[1]), .G2(g_4[2]), .G3(g_4[3]), .G17(g17_4),
        .BUSY(busy_4), .DONE(done_4), .PASS(pass_4)
`ifdef S27_BIST_SIG_OUT_EN
        , .SIG(sig_4)
`endif
    );

    s27_bist_ctrl u64 (
        .CK(CK), .RSTN(RSTN), .START(start_64),
        .G0(g_64[0]), .G1(g_64[1]), .G2(g_64[2]), .G3(g_64[3]), .G17(g17_64),
        .BUSY(busy_64), .DONE(done_64), .PASS(pass_64)
`ifdef S27_BIST_SIG_OUT_EN
        , .SIG(sig_64)
`endif
    );

    s27_bist_ctrl #(.PAT_COUNT(1), .GOLDEN_SIG(8'h01)) u1a (
        .CK(CK), .RSTN(RSTN), .START(start_1),
        .G0(g_1a[0]), .G1(g_1a[1]), .G2(g_1a[2]), .G3(g_1a[3]), .G17(1'b1),
        .BUSY(busy_1a), .DONE(done_1a), .PASS(pass_1a)
`ifdef S27_BIST_SIG_OUT_EN
        , .SIG(sig_1a)
`endif
    );

    s27_bist_ctrl #(.PAT_COUNT(1), .GOLDEN_SIG(8'h02)) u1b (
        .CK(CK), .RSTN(RSTN), .START(start_1),
        .G0(g_1b[0]), .G1(g_1b[1]), .G2(g_1b[2]), .G3(g_1b[3]), .G17(1'b1),
        .BUSY(busy_1b), .DONE(done_1b), .PASS(pass_1b)
`ifdef S27_BIST_SIG_OUT_EN
        , .SIG(sig_1b)
`endif
    );

`ifndef S27_BIST_SIG_OUT_EN
    assign sig_4  = u4.sig_q;
    assign sig_64 = u64.sig_q;
    assign sig_1a = u1a.sig_q;
    assign sig_1b = u1b.sig_q;
`endif

    logic [3:0] pat_tab [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // s27 combinational response with its internal flops held at zero.
    function automatic logic cut(input logic [3:0] g);
        return !(g[3] & !g[1]);
    endfunction

    function automatic logic [7:0] sisr(input logic [7:0] s, input logic b);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ b};
    endfunction

    // mode 0: G17=0, 1: random G17 (also during flush), 2: s27 response
    task automatic run64(input int mode, output logic [7:0] dut_sig);
        logic [7:0] msig;
        logic [3:0] eg;
        logic b;
        msig = 8'h00;
        dut_sig = 8'h00;
        start_64 = 1'b1;
        @(posedge CK); #1;
        start_64 = 1'b0;
        for (int c = 0; c <= F + P; c++) begin
            if (c < F) eg = 4'b0000;
            else if (c < F + P) eg = pat_tab[(c - F) % 15];
            else eg = 4'b0000;
            chk($sformatf("run64_g c=%0d", c), 32'(g_64), 32'(eg));
            chk($sformatf("run64_busy c=%0d", c), 32'(busy_64), 32'(c < F + P));
            chk($sformatf("run64_done c=%0d", c), 32'(done_64), 32'(c == F + P));
            if (c == F + P) begin
                chk("run64_pass", 32'(pass_64), 32'(msig == 8'h00));
                chk("run64_sig", 32'(sig_64), 32'(msig));
                dut_sig = sig_64;
            end else begin
                if (c < F) begin
                    g17_64 = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                end else begin
                    if (mode == 1) b = 1'($urandom_range(0, 1));
                    else if (mode == 2) b = cut(eg);
                    else b = 1'b0;
                    g17_64 = b;
                    msig = sisr(msig, b);
                end
                @(posedge CK); #1;
            end
        end
        g17_64 = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic [3:0] g;
        logic       busy;
        logic       done;
        logic       pass;
    } vec_t;

    initial begin
        vec_t tab [17];
        logic [7:0] s1, s2, dummy;
        logic [3:0] p;

        p = SEED;
        for (int i = 0; i < 15; i++) begin
            pat_tab[i] = p;
            p = {p[2:0], p[3] ^ p[2]};
        end

        tab[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[3]  = '{1'b0, 4'b1001, 1'b1, 1'b0, 1'b0};
        tab[4]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b0};
        tab[5]  = '{1'b0, 4'b0110, 1'b1, 1'b0, 1'b0};
        tab[6]  = '{1'b0, 4'b1101, 1'b1, 1'b0, 1'b0};
        tab[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1};
        tab[8]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1};
        tab[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[12] = '{1'b0, 4'b1001, 1'b1, 1'b0, 1'b0};
        tab[13] = '{1'b0, 4'b0011, 1'b1, 1'b0, 1'b0};
        tab[14] = '{1'b0, 4'b0110, 1'b1, 1'b0, 1'b0};
        tab[15] = '{1'b0, 4'b1101, 1'b1, 1'b0, 1'b0};
        tab[16] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1};

        // reset state
        #12;
        chk("rst_g", 32'(g_64), 32'h0);
        chk("rst_busy", 32'(busy_64), 32'h0);
        chk("rst_done", 32'(done_64), 32'h0);
        chk("rst_pass", 32'(pass_64), 32'h0);
        chk("rst_sig", 32'(sig_64), 32'h0);
        #11 RSTN = 1'b1;
        repeat (2) @(posedge CK);
        #1;

        // vector table on the PAT_COUNT=4 instance
        for (int r = 0; r < 17; r++) begin
            start_4 = tab[r].start;
            @(posedge CK); #1;
            chk($sformatf("tab_g r=%0d", r), 32'(g_4), 32'(tab[r].g));
            chk($sformatf("tab_busy r=%0d", r), 32'(busy_4), 32'(tab[r].busy));
            chk($sformatf("tab_done r=%0d", r), 32'(done_4), 32'(tab[r].done));
            chk($sformatf("tab_pass r=%0d", r), 32'(pass_4), 32'(tab[r].pass));
        end
        start_4 = 1'b0;

        // START held high for a whole run: no restart while busy, restart from DONE
        start_4 = 1'b1;
        for (int c = 0; c <= F + 4 + 1; c++) begin
            @(posedge CK); #1;
            chk($sformatf("hold_busy c=%0d", c), 32'(busy_4), 32'(c != F + 4));
            chk($sformatf("hold_done c=%0d", c), 32'(done_4), 32'(c == F + 4));
            if (c >= F && c < F + 4)
                chk($sformatf("hold_g c=%0d", c), 32'(g_4), 32'(pat_tab[c - F]));
        end
        start_4 = 1'b0;
        repeat (10) @(posedge CK);
        #1;

        // PAT_COUNT=1, G17=1: signature 01, PASS only for golden 01
        start_1 = 1'b1;
        @(posedge CK); #1;
        start_1 = 1'b0;
        for (int c = 0; c <= F + 1; c++) begin
            chk($sformatf("p1_done c=%0d", c), 32'(done_1a), 32'(c == F + 1));
            if (c < F + 1) begin
                @(posedge CK); #1;
            end
        end
        chk("p1_sig", 32'(sig_1a), 32'h01);
        chk("p1_pass_golden01", 32'(pass_1a), 32'h1);
        chk("p1_pass_golden02", 32'(pass_1b), 32'h0);
        chk("p1b_done", 32'(done_1b), 32'h1);

        // full-length runs on the default instance
        run64(0, dummy);
        run64(1, dummy);
        run64(1, dummy);
        run64(2, s1);
        run64(2, s2);
        chk("s27_repeat", 32'(s2), 32'(s1));

        // reset during RUN cycle 10 aborts the run
        start_64 = 1'b1;
        @(posedge CK); #1;
        start_64 = 1'b0;
        for (int c = 0; c < F + 9; c++) begin
            g17_64 = 1'($urandom_range(0, 1));
            @(posedge CK); #1;
        end
        chk("abort_in_run", 32'(busy_64), 32'h1);
        #2 RSTN = 1'b0;
        #1;
        chk("abort_g", 32'(g_64), 32'h0);
        chk("abort_busy", 32'(busy_64), 32'h0);
        chk("abort_done", 32'(done_64), 32'h0);
        chk("abort_pass", 32'(pass_64), 32'h0);
        chk("abort_sig", 32'(sig_64), 32'h0);
        g17_64 = 1'b0;
        @(posedge CK);
        #3 RSTN = 1'b1;
        @(posedge CK); #1;
        chk("post_rst_idle", 32'(busy_64), 32'h0);
        run64(0, dummy);
        run64(1, dummy);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
